wb_host_master: RTL and testbench

WB_HOST_MASTER -- requirements
Module: wb_host_master

---
 rtl/wb_host_master.sv | 202 ++++++++++++++++++++
 tb/tb_wb_host_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_host_master.sv
// wb_host_master: queues host register commands in a small FIFO and
// replays them one at a time as Wishbone classic cycles with timeout.
//
// Ports:
//   i_clk, i_rst (async, active-low)
//   cmd  : i_cmd_valid/o_cmd_ready handshake, i_cmd_we/adr/data
//   wb   : o_wb_cyc/stb/we/adr/data, i_wb_data, i_wb_ack
//   rsp  : o_rsp_valid pulse, o_rsp_data, o_rsp_err (timeout)
//   o_busy : FIFO non-empty or bus cycle in flight
module wb_host_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_we,
  input  logic [15:0] i_cmd_adr,
  input  logic [15:0] i_cmd_data,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [15:0] o_wb_adr,
  output logic [15:0] o_wb_data,
  input  logic [15:0] i_wb_data,
  input  logic        i_wb_ack,
  output logic        o_rsp_valid,
  output logic [15:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_e;

  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [15:0] data;
  } cmd_t;

  state_e         state_q, state_d;
  cmd_t           mem_q [FIFO_DEPTH];
  cmd_t           mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    wait_q, wait_d;
  logic           wb_we_q, wb_we_d;
  logic [15:0]    wb_adr_q, wb_adr_d;
  logic [15:0]    wb_data_q, wb_data_d;
  logic [15:0]    rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;

  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           timeout_hit;
  cmd_t           cmd_in;
  cmd_t           head;

  assign full   = (cnt_q == CW'(FIFO_DEPTH));
  assign empty  = (cnt_q == '0);
  assign cmd_in = '{we: i_cmd_we, adr: i_cmd_adr, data: i_cmd_data};
  assign head   = mem_q[rptr_q];
  assign push   = i_cmd_valid && !full;
  assign pop    = (state_q == IDLE) && !empty;

  // wait_q counts completed BUS cycles, so the last allowed cycle
  // is the one where it reads TIMEOUT-1.
  assign timeout_hit = (wait_q == 16'(TIMEOUT - 1));

  // FIFO bookkeeping; push and pop may coincide
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = cmd_in;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!empty) state_d = BUS;
      BUS: begin
        if (i_wb_ack || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bus request and response datapath
  always_comb begin
    wb_we_d    = wb_we_q;
    wb_adr_d   = wb_adr_q;
    wb_data_d  = wb_data_q;
    wait_d     = wait_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (1'b1)
      pop: begin
        wb_we_d   = head.we;
        wb_adr_d  = head.adr;
        wb_data_d = head.data;
        wait_d    = '0;
      end
      (state_q == BUS): begin
        wait_d = wait_q + 16'd1;
        if (i_wb_ack) begin
          rsp_data_d = wb_we_q ? 16'h0000 : i_wb_data;
          rsp_err_d  = 1'b0;
        end else if (timeout_hit) begin
          rsp_data_d = 16'h0000;
          rsp_err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // datapath registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      wb_we_q    <= 1'b0;
      wb_adr_q   <= '0;
      wb_data_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      wb_we_q    <= wb_we_d;
      wb_adr_q   <= wb_adr_d;
      wb_data_q  <= wb_data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // outputs
  always_comb begin
    o_wb_cyc    = 1'b0;
    o_wb_stb    = 1'b0;
    o_rsp_valid = 1'b0;
    unique case (state_q)
      BUS: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
      end
      DONE:    o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign o_wb_we     = wb_we_q;
  assign o_wb_adr    = wb_adr_q;
  assign o_wb_data   = wb_data_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_cmd_ready = !full;
  assign o_busy      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_wb_host_master.sv
// tb_wb_host_master: vector table plus corner sequences for
// wb_host_master, with a queue scoreboard and a Wishbone slave model.
module tb_wb_host_master;

  localparam int          TO    = 8;
  localparam logic [15:0] NOACK = 16'hFFFF;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] data;
    logic [15:0] dly;
    logic [15:0] rdata;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          len;
  } rsp_t;

  logic        clk;
  logic        i_rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_we;
  logic [15:0] i_cmd_adr;
  logic [15:0] i_cmd_data;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [15:0] o_wb_adr;
  logic [15:0] o_wb_data;
  logic [15:0] i_wb_data;
  logic        i_wb_ack;
  logic        o_rsp_valid;
  logic [15:0] o_rsp_data;
  logic        o_rsp_err;
  logic        o_busy;

  logic        ack_r;
  logic        spur;
  int          checks;
  int          errors;
  vec_t        slave_q[$];
  rsp_t        sb_q[$];
  vec_t        vecs[8];

  assign i_wb_ack = ack_r | spur;

  wb_host_master #(
    .FIFO_DEPTH(4),
    .TIMEOUT   (TO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_we   (i_cmd_we),
    .i_cmd_adr  (i_cmd_adr),
    .i_cmd_data (i_cmd_data),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_stb   (o_wb_stb),
    .o_wb_we    (o_wb_we),
    .o_wb_adr   (o_wb_adr),
    .o_wb_data  (o_wb_data),
    .i_wb_data  (i_wb_data),
    .i_wb_ack   (i_wb_ack),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_data (o_rsp_data),
    .o_rsp_err  (o_rsp_err),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // slave model and response monitor, sampled on the falling edge
  initial begin : slave_mon
    int   cnt;
    int   last_len;
    vec_t cur;
    rsp_t e;
    cnt       = 0;
    last_len  = 0;
    ack_r     = 1'b0;
    i_wb_data = 16'hDEAD;
    cur       = '{1'b0, 16'h0, 16'h0, NOACK, 16'h0, 16'h0, 1'b0};
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        cnt   = 0;
        ack_r = 1'b0;
      end else begin
        if (o_wb_stb) begin
          check("cyc_with_stb", o_wb_cyc, 1'b1);
          if (cnt == 0) begin
            if (slave_q.size() == 0) begin
              check("unexpected_stb", 1'b1, 1'b0);
              cur.dly = NOACK;
            end else begin
              cur = slave_q.pop_front();
              check("wb_we", o_wb_we, cur.we);
              if (cur.we) check("wb_data", o_wb_data, cur.data);
            end
          end
          check("wb_adr", o_wb_adr, cur.adr);
          ack_r     = (cnt == int'(cur.dly));
          i_wb_data = ack_r ? cur.rdata : 16'hDEAD;
          cnt++;
        end else begin
          if (o_wb_cyc) check("cyc_without_stb", 1'b1, 1'b0);
          if (cnt != 0) last_len = cnt;
          cnt       = 0;
          ack_r     = 1'b0;
          i_wb_data = 16'hDEAD;
        end
        if (o_rsp_valid) begin
          if (sb_q.size() == 0) begin
            check("unexpected_rsp", 1'b1, 1'b0);
          end else begin
            e = sb_q.pop_front();
            check("rsp_data", o_rsp_data, e.data);
            check("rsp_err", o_rsp_err, e.err);
            check("stb_len", last_len, e.len);
          end
        end
      end
    end
  end

  task automatic push(input vec_t v, input bit sync);
    int   n;
    rsp_t r;
    if (sync) @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_we    = v.we;
    i_cmd_adr   = v.adr;
    i_cmd_data  = v.data;
    n = 0;
    while (!o_cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("push_timeout", 1'b1, 1'b0);
    slave_q.push_back(v);
    r.data = v.exp_data;
    r.err  = v.exp_err;
    r.len  = v.exp_err ? TO : int'(v.dly) + 1;
    sb_q.push_back(r);
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || o_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 1'b1, 1'b0);
  endtask

  function automatic vec_t rd(input logic [15:0] a,
                              input logic [15:0] d,
                              input logic [15:0] rv);
    return '{1'b0, a, 16'h0, d, rv, rv, 1'b0};
  endfunction

  initial begin : main
    int   n;
    vec_t tmo;
    checks      = 0;
    errors      = 0;
    spur        = 1'b0;
    i_rst       = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_we    = 1'b0;
    i_cmd_adr   = 16'h0;
    i_cmd_data  = 16'h0;

    vecs[0] = '{1'b1, 16'h0000, 16'h0016, 16'd2, 16'h5A5A, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 16'h0004, 16'h0000, 16'd0, 16'h03E8, 16'h03E8, 1'b0};
    vecs[2] = '{1'b0, 16'h0004, 16'h0000, NOACK, 16'h0000, 16'h0000, 1'b1};
    vecs[3] = '{1'b1, 16'h1234, 16'hBEEF, 16'd0, 16'hFFFF, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 16'hABCD, 16'h0000, 16'd5, 16'h8001, 16'h8001, 1'b0};
    vecs[5] = '{1'b1, 16'hFFFF, 16'hFFFF, NOACK, 16'h0000, 16'h0000, 1'b1};
    vecs[6] = '{1'b0, 16'h0002, 16'h0000, 16'd7, 16'h7777, 16'h7777, 1'b0};
    vecs[7] = '{1'b1, 16'h00F0, 16'hC3C3, 16'd1, 16'h1111, 16'h0000, 1'b0};
    tmo     = vecs[2];

    // reset state, before any clock edge
    #3;
    check("rst_cyc", o_wb_cyc, 1'b0);
    check("rst_stb", o_wb_stb, 1'b0);
    check("rst_we", o_wb_we, 1'b0);
    check("rst_adr", o_wb_adr, 16'h0);
    check("rst_wdata", o_wb_data, 16'h0);
    check("rst_rsp_valid", o_rsp_valid, 1'b0);
    check("rst_rsp_err", o_rsp_err, 1'b0);
    check("rst_rsp_data", o_rsp_data, 16'h0);
    check("rst_ready", o_cmd_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b1;

    // vector table, one transaction at a time
    for (int i = 0; i < 8; i++) begin
      push(vecs[i], 1'b1);
      drain();
      check("idle_after_vec", o_busy, 1'b0);
    end

    // ack while idle is ignored
    @(negedge clk);
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    check("spur_busy", o_busy, 1'b0);
    check("spur_no_rsp", o_rsp_valid, 1'b0);

    // fill the FIFO behind a timing-out read
    push(tmo, 1'b1);
    push(rd(16'h0000, 16'd1, 16'h0101), 1'b1);
    push(rd(16'h0002, 16'd1, 16'h0202), 1'b1);
    push(rd(16'h0004, 16'd1, 16'h0303), 1'b1);
    push(rd(16'h0006, 16'd1, 16'h0404), 1'b1);
    @(negedge clk);
    check("full_ready", o_cmd_ready, 1'b0);
    check("full_busy", o_busy, 1'b1);
    push(rd(16'h0000, 16'd1, 16'h0505), 1'b0);
    drain();
    check("full_drained", o_busy, 1'b0);

    // push on the DONE->IDLE edge, then on a pop edge
    push(rd(16'h0010, 16'd0, 16'hA001), 1'b1);
    push(rd(16'h0012, 16'd2, 16'hA002), 1'b1);
    n = 0;
    while (!o_rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", o_rsp_valid, 1'b1);
    push(rd(16'h0014, 16'd0, 16'hA003), 1'b0);
    push(rd(16'h0016, 16'd1, 16'hA004), 1'b1);
    drain();
    check("pp_drained", o_busy, 1'b0);

    // reset in the middle of a bus cycle with two queued
    push(tmo, 1'b1);
    push(rd(16'h0020, 16'd0, 16'hB001), 1'b1);
    push(rd(16'h0022, 16'd0, 16'hB002), 1'b1);
    n = 0;
    while (!o_wb_stb && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_stb_seen", o_wb_stb, 1'b1);
    @(negedge clk);
    #2;
    i_rst = 1'b0;
    #1;
    check("mid_cyc", o_wb_cyc, 1'b0);
    check("mid_stb", o_wb_stb, 1'b0);
    check("mid_busy", o_busy, 1'b0);
    check("mid_rsp_valid", o_rsp_valid, 1'b0);
    slave_q.delete();
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_busy", o_busy, 1'b0);
    check("post_rst_ready", o_cmd_ready, 1'b1);
    check("post_rst_stb", o_wb_stb, 1'b0);

    // still operational after the reset
    push(vecs[1], 1'b1);
    drain();
    check("final_idle", o_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
